// File: rtl/uart_pkt_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkt_scheduler_pkg
//   Shared definitions for the UART packet scheduler: FSM state encoding,
//   packet-type codes, default sync byte, status length and a helper that
//   picks a status payload byte (most significant byte first).
// ---------------------------------------------------------------------------
package uart_pkt_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TYPE,
        ST_LENH,
        ST_LENL,
        ST_PAYLOAD,
        ST_CSUM
    } state_e;

    localparam logic [7:0]  PKT_STAT      = 8'h01;
    localparam logic [7:0]  PKT_DUMP      = 8'h02;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [15:0] STAT_LEN      = 16'd4;

    // Byte idx of the status word, idx 0 = bits [31:24].
    function automatic logic [7:0] stat_byte(input logic [31:0] word, input logic [1:0] idx);
        unique case (idx)
            2'd0:    stat_byte = word[31:24];
            2'd1:    stat_byte = word[23:16];
            2'd2:    stat_byte = word[15:8];
            default: stat_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_rd_edge.sv
// ---------------------------------------------------------------------------
// uart_rd_edge
//   Detects the rising edge of the serializer's byte-read strobe.
//   clk_i    : bit-rate clock
//   rst_i    : synchronous active-high reset
//   rd_i     : serializer read strobe (high on last 3 cycles of a frame)
//   accept_o : 1-cycle pulse, current byte has been consumed
// ---------------------------------------------------------------------------
module uart_rd_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rd_i,
    output logic accept_o
);

    logic rd_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_i;
        end
    end

    assign accept_o = rd_i & ~rd_q;

endmodule

// File: rtl/uart_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// uart_pkt_scheduler
//   Shares a byte-serial UART transmitter between a status report and a
//   capture-buffer dump. Each transfer is framed as
//   SYNC, TYPE, LENH, LENL, payload..., CSUM; CSUM is the mod-256 sum of
//   everything after SYNC. Pacing comes only from UartRd rising edges.
//
//   SendingCLK : bit-rate clock           Init     : sync active-high reset
//   DumpReq    : dump request pulse       StatReq  : status request pulse
//   StatWord   : status payload (captured at grant)
//   Busy       : packet in progress       DumpDone/StatDone : end pulses
//   MemAddr    : capture RAM address      MemData  : RAM data (1-cycle latency)
//   UartEN     : serializer enable        UartData : byte to serializer
//   UartRd     : serializer read strobe
// ---------------------------------------------------------------------------
module uart_pkt_scheduler
    import uart_pkt_scheduler_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         DUMP_LEN  = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              SendingCLK,
    input  logic              Init,
    input  logic              DumpReq,
    input  logic              StatReq,
    input  logic [31:0]       StatWord,
    output logic              Busy,
    output logic              DumpDone,
    output logic              StatDone,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemData,
    output logic              UartEN,
    output logic [7:0]        UartData,
    input  logic              UartRd
);

    localparam logic [15:0] DUMP_LEN16 = 16'(DUMP_LEN);

    state_e            state_q;
    logic              is_stat_q;
    logic [31:0]       stat_word_q;
    logic [15:0]       cnt_q;
    logic [7:0]        csum_q;
    logic              stat_pend_q;
    logic              dump_pend_q;
    logic              uart_en_q;
    logic [7:0]        uart_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              dump_done_q;
    logic              stat_done_q;

    logic              accept;
    logic [15:0]       pkt_len;
    logic [7:0]        payload_byte;
    logic [7:0]        next_byte_d;
    logic [7:0]        csum_d;

    uart_rd_edge u_rd_edge (
        .clk_i    (SendingCLK),
        .rst_i    (Init),
        .rd_i     (UartRd),
        .accept_o (accept)
    );

    assign pkt_len      = is_stat_q ? STAT_LEN : DUMP_LEN16;
    // MemData already holds RAM[cnt_q]: the address was issued a full frame ago.
    assign payload_byte = is_stat_q ? stat_byte(stat_word_q, cnt_q[1:0]) : MemData;

    // Byte loaded into UartData on the next acceptance (header or payload).
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        next_byte_d = payload_byte;
        case (state_q)
            ST_SYNC: next_byte_d = is_stat_q ? PKT_STAT : PKT_DUMP;
            ST_TYPE: next_byte_d = pkt_len[15:8];
            ST_LENH: next_byte_d = pkt_len[7:0];
            default: ;
        endcase
    end

    assign csum_d = csum_q + next_byte_d;

    always_ff @(posedge SendingCLK) begin
        if (Init) begin
            state_q     <= ST_IDLE;
            is_stat_q   <= 1'b0;
            stat_word_q <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            stat_pend_q <= 1'b0;
            dump_pend_q <= 1'b0;
            uart_en_q   <= 1'b0;
            uart_data_q <= '0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
            stat_done_q <= 1'b0;
        end else begin
            dump_done_q <= 1'b0;
            stat_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Status has fixed priority; the losing flag stays set.
                    if (stat_pend_q || dump_pend_q) begin
                        is_stat_q   <= stat_pend_q;
                        if (stat_pend_q) begin
                            stat_pend_q <= 1'b0;
                            stat_word_q <= StatWord;
                        end else begin
                            dump_pend_q <= 1'b0;
                        end
                        state_q     <= ST_SYNC;
                        uart_data_q <= SYNC_BYTE;
                        uart_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        csum_q      <= '0;
                        cnt_q       <= '0;
                        mem_addr_q  <= '0;
                    end
                end
                ST_SYNC, ST_TYPE, ST_LENH: begin
                    if (accept) begin
                        uart_data_q <= next_byte_d;
                        csum_q      <= csum_d;
                        state_q     <= (state_q == ST_SYNC) ? ST_TYPE :
                                       (state_q == ST_TYPE) ? ST_LENH : ST_LENL;
                    end
                end
                ST_LENL, ST_PAYLOAD: begin
                    if (accept) begin
                        if (state_q == ST_PAYLOAD && cnt_q == pkt_len) begin
                            state_q     <= ST_CSUM;
                            uart_data_q <= csum_q;
                        end else begin
                            // Enter payload byte cnt_q and prefetch the next address.
                            state_q     <= ST_PAYLOAD;
                            uart_data_q <= next_byte_d;
                            csum_q      <= csum_d;
                            cnt_q       <= cnt_q + 16'd1;
                            mem_addr_q  <= ADDR_W'(cnt_q + 16'd1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        state_q     <= ST_IDLE;
                        uart_en_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        stat_done_q <= is_stat_q;
                        dump_done_q <= ~is_stat_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Written last so a request always wins over the grant clear.
            if (StatReq) stat_pend_q <= 1'b1;
            if (DumpReq) dump_pend_q <= 1'b1;
        end
    end

    assign Busy     = busy_q;
    assign DumpDone = dump_done_q;
    assign StatDone = stat_done_q;
    assign MemAddr  = mem_addr_q;
    assign UartEN   = uart_en_q;
    assign UartData = uart_data_q;

endmodule
